bf_run_controller: RTL and testbench

//  Sequencer and RAM owner for one brainfuckCore. Holds the core in reset while a program streams in

---
 rtl/bf_run_controller_pkg.sv | 19 +
 rtl/bf_ram_clearer.sv | 58 +++++
 rtl/bf_run_controller.sv | 172 +++++++++++++++++
 tb/tb_bf_run_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/bf_run_controller_pkg.sv
// -----------------------------------------------------------------------------
// bf_run_controller_pkg
// Shared definitions for the brainfuck run controller: the 2-bit sequencer
// state encoding and the program terminator byte. Imported by the controller
// and by benches that want to name states or the terminator.
// -----------------------------------------------------------------------------
package bf_run_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CLEAR = 2'd2,
        S_RUN   = 2'd3
    } bf_state_e;

    // Program terminator; also forced into the last code slot on overflow.
    localparam logic [7:0] BF_TERM_BYTE = 8'h00;

endpackage

// File: rtl/bf_ram_clearer.sv
// -----------------------------------------------------------------------------
// bf_ram_clearer
// Sweeps a data-RAM address counter 0 .. 2**ADDR_W-1, one address per cycle,
// after a start pulse.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-low reset
//   start_i  in   1-cycle pulse; the sweep begins on the following cycle
//   active_o out  1 on every sweep cycle (use as write enable)
//   addr_o   out  current sweep address
//   done_o   out  1 on the final sweep cycle (address all-ones)
// -----------------------------------------------------------------------------
module bf_ram_clearer #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    output logic              active_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    logic              active_q, active_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_MAX) begin
                active_d = 1'b0;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    assign active_o = active_q;
    assign addr_o   = cnt_q;
    assign done_o   = active_q && (cnt_q == ADDR_MAX);

endmodule

// File: rtl/bf_run_controller.sv
// -----------------------------------------------------------------------------
// bf_run_controller
// Sequencer and RAM owner for one brainfuckCore. Streams a program into the
// code RAM while the core is held in reset, zeroes the data RAM, then releases
// the core and passes its data-RAM port straight through.
// Ports:
//   clk, reset (async active-low)
//   load_start                      pulse: begin a program load (IDLE or RUN)
//   byte_in_valid/byte_in/_ready    program byte stream
//   code_we/code_addr/code_data     registered code RAM write port
//   core_array_addr/_data/_we       core's data-RAM request (used only in RUN)
//   ram_addr/ram_data/ram_we        data RAM port (clear sweep or core)
//   core_reset                      active-low core reset, high only in RUN
//   running                         high only in RUN
//   overflow                        sticky: last load filled capacity unterminated
// -----------------------------------------------------------------------------
module bf_run_controller
    import bf_run_controller_pkg::*;
#(
    parameter int CODE_ADDR_W  = 5,
    parameter int ARRAY_ADDR_W = 5,
    parameter int DATA_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_start,
    input  logic                    byte_in_valid,
    input  logic [DATA_W-1:0]       byte_in,
    output logic                    byte_in_ready,
    output logic                    code_we,
    output logic [CODE_ADDR_W-1:0]  code_addr,
    output logic [DATA_W-1:0]       code_data,
    input  logic [ARRAY_ADDR_W-1:0] core_array_addr,
    input  logic [DATA_W-1:0]       core_array_data,
    input  logic                    core_array_we,
    output logic [ARRAY_ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0]       ram_data,
    output logic                    ram_we,
    output logic                    core_reset,
    output logic                    running,
    output logic                    overflow
);

    localparam logic [CODE_ADDR_W-1:0] CODE_MAX = {CODE_ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0]      TERM     = DATA_W'(BF_TERM_BYTE);

    bf_state_e              state_q, state_d;
    logic [CODE_ADDR_W-1:0] load_cnt_q, load_cnt_d;
    logic                   code_we_q, code_we_d;
    logic [CODE_ADDR_W-1:0] code_addr_q, code_addr_d;
    logic [DATA_W-1:0]      code_data_q, code_data_d;
    logic                   overflow_q, overflow_d;
    logic                   core_reset_q, core_reset_d;
    logic                   running_q, running_d;

    logic                    clr_start, clr_active, clr_done;
    logic [ARRAY_ADDR_W-1:0] clr_addr;

    bf_ram_clearer #(.ADDR_W(ARRAY_ADDR_W)) u_clearer (
        .clk      (clk),
        .reset    (reset),
        .start_i  (clr_start),
        .active_o (clr_active),
        .addr_o   (clr_addr),
        .done_o   (clr_done)
    );

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        code_we_d    = 1'b0;
        code_addr_d  = code_addr_q;
        code_data_d  = code_data_q;
        overflow_d   = overflow_q;
        core_reset_d = core_reset_q;
        running_d    = running_q;
        clr_start    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d    = S_LOAD;
                    load_cnt_d = '0;
                    overflow_d = 1'b0;
                end
            end
            S_LOAD: begin
                // ready is constant 1 here, so valid alone is an accept
                if (byte_in_valid) begin
                    code_we_d   = 1'b1;
                    code_addr_d = load_cnt_q;
                    code_data_d = byte_in;
                    load_cnt_d  = load_cnt_q + 1'b1;
                    if (byte_in == TERM || load_cnt_q == CODE_MAX) begin
                        state_d   = S_CLEAR;
                        clr_start = 1'b1;
                    end
                    // Last slot reached without a terminator: store one anyway
                    if (load_cnt_q == CODE_MAX && byte_in != TERM) begin
                        code_data_d = TERM;
                        overflow_d  = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (clr_done) begin
                    state_d      = S_RUN;
                    core_reset_d = 1'b1;
                    running_d    = 1'b1;
                end
            end
            S_RUN: begin
                // Core is put back into reset on the same edge that enters
                // LOAD, before any code write lands.
                if (load_start) begin
                    state_d      = S_LOAD;
                    load_cnt_d   = '0;
                    overflow_d   = 1'b0;
                    core_reset_d = 1'b0;
                    running_d    = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            code_we_q    <= 1'b0;
            code_addr_q  <= '0;
            code_data_q  <= '0;
            overflow_q   <= 1'b0;
            core_reset_q <= 1'b0;
            running_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            code_we_q    <= code_we_d;
            code_addr_q  <= code_addr_d;
            code_data_q  <= code_data_d;
            overflow_q   <= overflow_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
        end
    end

    // Data RAM mux: sweep owns it in CLEAR, the core in RUN, nobody otherwise.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_data = '0;
        if (state_q == S_CLEAR) begin
            ram_we   = clr_active;
            ram_addr = clr_addr;
        end else if (state_q == S_RUN) begin
            ram_we   = core_array_we;
            ram_addr = core_array_addr;
            ram_data = core_array_data;
        end
    end

    assign byte_in_ready = (state_q == S_LOAD);
    assign code_we       = code_we_q;
    assign code_addr     = code_addr_q;
    assign code_data     = code_data_q;
    assign overflow      = overflow_q;
    assign core_reset    = core_reset_q;
    assign running       = running_q;

endmodule

// File: tb/tb_bf_run_controller.sv
// -----------------------------------------------------------------------------
// tb_bf_run_controller
// Scoreboard bench: stimulus pushes expected code-RAM and clear-sweep writes
// into queues; a negedge monitor pops and compares whenever the DUT writes.
// -----------------------------------------------------------------------------
module tb_bf_run_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_start = 1'b0;
    logic       byte_in_valid = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_in_ready;
    logic       code_we;
    logic [4:0] code_addr;
    logic [7:0] code_data;
    logic [4:0] core_array_addr = 5'd0;
    logic [7:0] core_array_data = 8'h00;
    logic       core_array_we = 1'b0;
    logic [4:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       core_reset;
    logic       running;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    int code_q[$];   // {addr,data} packed as addr*256+data
    int ram_q[$];

    bf_run_controller #(.CODE_ADDR_W(5), .ARRAY_ADDR_W(5), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .byte_in_valid(byte_in_valid), .byte_in(byte_in), .byte_in_ready(byte_in_ready),
        .code_we(code_we), .code_addr(code_addr), .code_data(code_data),
        .core_array_addr(core_array_addr), .core_array_data(core_array_data),
        .core_array_we(core_array_we),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .core_reset(core_reset), .running(running), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every code write and every non-RUN data-RAM write must match
    // the head of its queue.
    always @(negedge clk) begin
        if (code_we) begin
            if (code_q.size() == 0) chk("code_unexpected", {code_addr, code_data}, -1);
            else chk("code_write", {code_addr, code_data}, code_q.pop_front());
        end
        if (ram_we && !running) begin
            if (ram_q.size() == 0) chk("clear_unexpected", {ram_addr, ram_data}, -1);
            else chk("clear_write", {ram_addr, ram_data}, ram_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_load();
        load_start = 1'b1; tick(); load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int addr, input logic [7:0] exp);
        byte_in_valid = 1'b1; byte_in = b;
        code_q.push_back(addr * 256 + int'(exp));
        tick();
        byte_in_valid = 1'b0;
    endtask

    task automatic push_clear(input int last);
        for (int a = 0; a <= last; a++) ram_q.push_back(a * 256);
    endtask

    task automatic wait_running(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (running) ok = 1'b1;
        end
        chk(name, int'(ok), 1);
    endtask

    initial begin
        // 1. reset
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_core_reset", core_reset, 0);
        chk("rst_ram_we", ram_we, 0);
        #1 reset = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_core_reset", core_reset, 0);
        chk("idle_running", running, 0);
        chk("idle_ready", byte_in_ready, 0);
        chk("idle_ram_we", ram_we, 0);
        chk("idle_code_we", code_we, 0);
        chk("idle_overflow", overflow, 0);

        // 2. "+++." then terminator
        tick();
        pulse_load();
        @(negedge clk);
        chk("load_ready", byte_in_ready, 1);
        chk("load_ram_we", ram_we, 0);
        tick();
        send(8'h2B, 0, 8'h2B); byte_in_valid = 1'b1;
        send(8'h2B, 1, 8'h2B); byte_in_valid = 1'b1;
        send(8'h2B, 2, 8'h2B); byte_in_valid = 1'b1;
        send(8'h2E, 3, 8'h2E); byte_in_valid = 1'b1;
        push_clear(31);
        send(8'h00, 4, 8'h00);
        chk("t2_core_held", core_reset, 0);
        wait_running("t2_reach_run");
        chk("t2_core_reset", core_reset, 1);
        chk("t2_overflow", overflow, 0);
        chk("t2_code_left", code_q.size(), 0);
        chk("t2_clear_left", ram_q.size(), 0);

        // 5. core pass-through in RUN, then abort with load_start
        tick();
        core_array_addr = 5'd7; core_array_data = 8'h41; core_array_we = 1'b1;
        @(negedge clk);
        chk("run_ram_addr", ram_addr, 7);
        chk("run_ram_data", ram_data, 8'h41);
        chk("run_ram_we", ram_we, 1);
        tick();
        core_array_we = 1'b0;
        pulse_load();
        @(negedge clk);
        chk("abort_core_reset", core_reset, 0);
        chk("abort_running", running, 0);
        chk("abort_ready", byte_in_ready, 1);
        core_array_we = 1'b1;   // must be ignored outside RUN
        #1 chk("abort_ram_we", ram_we, 0);
        tick();
        core_array_we = 1'b0;

        // 3 + 4. 32 x '+' with a 3-cycle valid gap after 10 bytes
        for (int i = 0; i < 32; i++) begin
            if (i == 10) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    chk("gap_code_we", code_we, i == 10 && g == 0 ? 1 : 0);
                    tick();
                end
            end
            if (i == 31) push_clear(31);
            byte_in_valid = 1'b1;
            send(8'h2B, i, i == 31 ? 8'h00 : 8'h2B);
        end
        @(negedge clk);
        chk("t3_ready_after", byte_in_ready, 0);
        chk("t3_overflow", overflow, 1);
        wait_running("t3_reach_run");
        chk("t3_overflow_run", overflow, 1);
        chk("t3_code_left", code_q.size(), 0);
        chk("t3_clear_left", ram_q.size(), 0);

        // 6. reset during CLEAR at address 10
        tick();
        pulse_load();
        push_clear(10);
        send(8'h00, 0, 8'h00);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 60 && !hit; i++) begin
                @(negedge clk);
                if (ram_we && !running && ram_addr == 5'd10) hit = 1'b1;
            end
            chk("t6_reach_addr10", int'(hit), 1);
        end
        #1 reset = 1'b0;
        #1;
        chk("t6_ram_we", ram_we, 0);
        chk("t6_core_reset", core_reset, 0);
        chk("t6_ready", byte_in_ready, 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("t6_no_release", core_reset, 0);
        chk("t6_not_running", running, 0);
        chk("t6_overflow", overflow, 0);
        chk("end_code_left", code_q.size(), 0);
        chk("end_clear_left", ram_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
